// File: rtl/clock_timekeeper_if.sv
// clock_timekeeper_if
//   Groups the button inputs and the display-facing outputs of the
//   timekeeper into one bundle.
//   master : the side that issues button pulses and consumes the display
//            fields (display driver / testbench).
//   slave  : the timekeeper itself.
//   Signals:
//     btn_mode, btn_next, btn_inc    debounced single-cycle button pulses
//     mode[1:0]                      00 SETUP, 01 TIME24, 10 SECONDS, 11 TIME12
//     location[1:0]                  edit cursor (0 hoursUpper .. 3 minutesLower)
//     secondsLower/Upper, minutesLower/Upper, hoursLower/Upper [3:0]
//                                    BCD digits (hours already 12h-mapped in TIME12)
//     blink                          half-second square wave
//     pm                             internal 24h hour is 12..23
interface clock_timekeeper_if;
  logic       btn_mode;
  logic       btn_next;
  logic       btn_inc;
  logic [1:0] mode;
  logic [1:0] location;
  logic [3:0] secondsLower;
  logic [3:0] secondsUpper;
  logic [3:0] minutesLower;
  logic [3:0] minutesUpper;
  logic [3:0] hoursLower;
  logic [3:0] hoursUpper;
  logic       blink;
  logic       pm;

  modport master (
    output btn_mode, btn_next, btn_inc,
    input  mode, location,
    input  secondsLower, secondsUpper, minutesLower, minutesUpper,
    input  hoursLower, hoursUpper, blink, pm
  );

  modport slave (
    input  btn_mode, btn_next, btn_inc,
    output mode, location,
    output secondsLower, secondsUpper, minutesLower, minutesUpper,
    output hoursLower, hoursUpper, blink, pm
  );
endinterface

// File: rtl/clock_timekeeper.sv
// clock_timekeeper
//   BCD time-of-day counter with SETUP/TIME24/SECONDS/TIME12 mode control
//   and digit editing, feeding the seven-segment display driver.
//   Parameters:
//     CLK_HZ  clock frequency; one seconds tick every CLK_HZ cycles (>= 4)
//   Ports:
//     clk     system clock, rising edge
//     rst_n   asynchronous active-low reset
//     bus     clock_timekeeper_if.slave: buttons in, display fields out
//   The hours store is always 24-hour; the 12-hour view is derived when the
//   output register is loaded, so every output comes straight from a flop.
module clock_timekeeper #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clock_timekeeper_if.slave    bus
);

  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HALF = CLK_HZ / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  typedef enum logic [1:0] {
    SETUP   = 2'b00,
    TIME24  = 2'b01,
    SECONDS = 2'b10,
    TIME12  = 2'b11
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [1:0]    loc_q, loc_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic [3:0]    sec_lo_q, sec_lo_d, sec_up_q, sec_up_d;
  logic [3:0]    min_lo_q, min_lo_d, min_up_q, min_up_d;
  logic [3:0]    hr_lo_q, hr_lo_d, hr_up_q, hr_up_d;
  logic [3:0]    hr_out_lo_q, hr_out_lo_d, hr_out_up_q, hr_out_up_d;
  logic          pm_q, pm_d;
  logic          tick;
  logic [4:0]    hr_bin, disp_bin;

  // Mode FSM, cursor, prescaler and time digits
  always_comb begin
    mode_d   = mode_q;
    loc_d    = loc_q;
    presc_d  = presc_q;
    sec_lo_d = sec_lo_q;
    sec_up_d = sec_up_q;
    min_lo_d = min_lo_q;
    min_up_d = min_up_q;
    hr_lo_d  = hr_lo_q;
    hr_up_d  = hr_up_q;
    tick     = 1'b0;

    if (bus.btn_mode) begin
      case (mode_q)
        SETUP:   mode_d = TIME24;
        TIME24:  mode_d = SECONDS;
        SECONDS: mode_d = TIME12;
        default: mode_d = SETUP;
      endcase
    end

    if (mode_q == SETUP) begin
      presc_d = '0;
      if (bus.btn_mode) begin
        // leaving SETUP starts the minute afresh
        sec_lo_d = 4'd0;
        sec_up_d = 4'd0;
      end else if (bus.btn_next) begin
        loc_d = loc_q + 2'd1;
      end else if (bus.btn_inc) begin
        case (loc_q)
          2'd0: begin
            hr_up_d = (hr_up_q >= 4'd2) ? 4'd0 : hr_up_q + 4'd1;
            // keep the hour legal when the tens digit reaches 2
            if (hr_up_d == 4'd2 && hr_lo_q > 4'd3) hr_lo_d = 4'd3;
          end
          2'd1: hr_lo_d = (hr_lo_q >= ((hr_up_q == 4'd2) ? 4'd3 : 4'd9)) ? 4'd0 : hr_lo_q + 4'd1;
          2'd2: min_up_d = (min_up_q >= 4'd5) ? 4'd0 : min_up_q + 4'd1;
          default: min_lo_d = (min_lo_q >= 4'd9) ? 4'd0 : min_lo_q + 4'd1;
        endcase
      end
    end else begin
      tick    = (presc_q == PRESC_MAX);
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (mode_d == SETUP) presc_d = '0;
      // a tick coinciding with the return to SETUP is discarded
      if (tick && mode_d != SETUP) begin
        if (sec_lo_q >= 4'd9) begin
          sec_lo_d = 4'd0;
          if (sec_up_q >= 4'd5) begin
            sec_up_d = 4'd0;
            if (min_lo_q >= 4'd9) begin
              min_lo_d = 4'd0;
              if (min_up_q >= 4'd5) begin
                min_up_d = 4'd0;
                if (hr_up_q == 4'd2 && hr_lo_q >= 4'd3) begin
                  hr_up_d = 4'd0;
                  hr_lo_d = 4'd0;
                end else if (hr_lo_q >= 4'd9) begin
                  hr_lo_d = 4'd0;
                  hr_up_d = hr_up_q + 4'd1;
                end else begin
                  hr_lo_d = hr_lo_q + 4'd1;
                end
              end else begin
                min_up_d = min_up_q + 4'd1;
              end
            end else begin
              min_lo_d = min_lo_q + 4'd1;
            end
          end else begin
            sec_up_d = sec_up_q + 4'd1;
          end
        end else begin
          sec_lo_d = sec_lo_q + 4'd1;
        end
      end
    end
  end

  // Hours view and PM flag, computed from the next internal value so the
  // displayed hours move on the same edge as the rest of the time.
  always_comb begin
    hr_bin   = 5'(hr_up_d) * 5'd10 + 5'(hr_lo_d);
    disp_bin = hr_bin;
    if (mode_d == TIME12) begin
      if (hr_bin == 5'd0)       disp_bin = 5'd12;
      else if (hr_bin > 5'd12)  disp_bin = hr_bin - 5'd12;
    end
    if (disp_bin >= 5'd20) begin
      hr_out_up_d = 4'd2;
      hr_out_lo_d = 4'(disp_bin - 5'd20);
    end else if (disp_bin >= 5'd10) begin
      hr_out_up_d = 4'd1;
      hr_out_lo_d = 4'(disp_bin - 5'd10);
    end else begin
      hr_out_up_d = 4'd0;
      hr_out_lo_d = 4'(disp_bin);
    end
    pm_d = (hr_bin >= 5'd12);
  end

  // Free-running blink divider, independent of mode
  always_comb begin
    blink_d = blink_q;
    bcnt_d  = bcnt_q + BW'(1);
    if (bcnt_q == BLINK_MAX) begin
      bcnt_d  = '0;
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= SETUP;
      loc_q       <= 2'd0;
      presc_q     <= '0;
      bcnt_q      <= '0;
      blink_q     <= 1'b0;
      sec_lo_q    <= 4'd0;
      sec_up_q    <= 4'd0;
      min_lo_q    <= 4'd0;
      min_up_q    <= 4'd0;
      hr_lo_q     <= 4'd0;
      hr_up_q     <= 4'd0;
      hr_out_lo_q <= 4'd0;
      hr_out_up_q <= 4'd0;
      pm_q        <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      loc_q       <= loc_d;
      presc_q     <= presc_d;
      bcnt_q      <= bcnt_d;
      blink_q     <= blink_d;
      sec_lo_q    <= sec_lo_d;
      sec_up_q    <= sec_up_d;
      min_lo_q    <= min_lo_d;
      min_up_q    <= min_up_d;
      hr_lo_q     <= hr_lo_d;
      hr_up_q     <= hr_up_d;
      hr_out_lo_q <= hr_out_lo_d;
      hr_out_up_q <= hr_out_up_d;
      pm_q        <= pm_d;
    end
  end

  assign bus.mode         = mode_q;
  assign bus.location     = loc_q;
  assign bus.secondsLower = sec_lo_q;
  assign bus.secondsUpper = sec_up_q;
  assign bus.minutesLower = min_lo_q;
  assign bus.minutesUpper = min_up_q;
  assign bus.hoursLower   = hr_out_lo_q;
  assign bus.hoursUpper   = hr_out_up_q;
  assign bus.blink        = blink_q;
  assign bus.pm           = pm_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// tb_clock_timekeeper
//   Cycle-level bench for clock_timekeeper with CLK_HZ=4. An integer-based
//   reference model of the clock is advanced once per cycle; the expected
//   output set is queued before each edge and compared after it.
module tb_clock_timekeeper;
  localparam int CLK_HZ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  clock_timekeeper_if ifc();

  clock_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode; int loc;
    int hu; int hl; int mu; int ml; int su; int sl;
    int blink; int pm;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  // reference model state (hours kept 0..23 as an integer)
  int m_mode, m_loc, m_h, m_m, m_s, m_p, m_bc, m_blink;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int hours_view(int h, int mode);
    if (mode != 3) return h;
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  function automatic int mdig(int loc);
    case (loc)
      0: return m_h / 10;
      1: return m_h % 10;
      2: return m_m / 10;
      default: return m_m % 10;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_loc = 0; m_h = 0; m_m = 0; m_s = 0;
    m_p = 0; m_bc = 0; m_blink = 0;
  endtask

  task automatic model_edit();
    int hu, hl, mu, ml;
    hu = m_h / 10; hl = m_h % 10; mu = m_m / 10; ml = m_m % 10;
    case (m_loc)
      0: begin hu = (hu + 1) % 3; if (hu == 2 && hl > 3) hl = 3; end
      1: hl = (hl + 1) % ((hu == 2) ? 4 : 10);
      2: mu = (mu + 1) % 6;
      default: ml = (ml + 1) % 10;
    endcase
    m_h = hu * 10 + hl;
    m_m = mu * 10 + ml;
  endtask

  task automatic model_cycle(bit bm, bit bn, bit bi);
    int om, nm;
    bit tick;
    om = m_mode;
    nm = bm ? (m_mode + 1) % 4 : m_mode;
    tick = (om != 0) && (m_p == CLK_HZ - 1);
    if (m_bc == CLK_HZ / 2 - 1) begin m_bc = 0; m_blink = 1 - m_blink; end
    else m_bc++;
    if (om == 0) begin
      if (bm) m_s = 0;
      else if (bn) m_loc = (m_loc + 1) % 4;
      else if (bi) model_edit();
    end else if (tick && nm != 0) begin
      m_s++;
      if (m_s == 60) begin
        m_s = 0; m_m++;
        if (m_m == 60) begin m_m = 0; m_h = (m_h + 1) % 24; end
      end
    end
    if (nm == 0 || om == 0 || tick) m_p = 0;
    else m_p++;
    m_mode = nm;
  endtask

  task automatic push_expected();
    exp_t e;
    int hv;
    hv = hours_view(m_h, m_mode);
    e.mode = m_mode; e.loc = m_loc;
    e.hu = hv / 10; e.hl = hv % 10;
    e.mu = m_m / 10; e.ml = m_m % 10;
    e.su = m_s / 10; e.sl = m_s % 10;
    e.blink = m_blink; e.pm = (m_h >= 12) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("mode", ifc.mode, e.mode);
    check("location", ifc.location, e.loc);
    check("hoursUpper", ifc.hoursUpper, e.hu);
    check("hoursLower", ifc.hoursLower, e.hl);
    check("minutesUpper", ifc.minutesUpper, e.mu);
    check("minutesLower", ifc.minutesLower, e.ml);
    check("secondsUpper", ifc.secondsUpper, e.su);
    check("secondsLower", ifc.secondsLower, e.sl);
    check("blink", ifc.blink, e.blink);
    check("pm", ifc.pm, e.pm);
  endtask

  // one clock cycle: drive buttons, predict, clock, compare
  task automatic step(bit bm, bit bn, bit bi);
    ifc.btn_mode = bm; ifc.btn_next = bn; ifc.btn_inc = bi;
    model_cycle(bm, bn, bi);
    push_expected();
    @(posedge clk);
    #1;
    ifc.btn_mode = 1'b0; ifc.btn_next = 1'b0; ifc.btn_inc = 1'b0;
    compare_outputs();
  endtask

  task automatic press(string name, bit bm, bit bn, bit bi);
    step(bm, bn, bi);
    $display("press %-9s mode=%0d loc=%0d out=%0d%0d:%0d%0d:%0d%0d pm=%0d", name,
             ifc.mode, ifc.location, ifc.hoursUpper, ifc.hoursLower,
             ifc.minutesUpper, ifc.minutesLower, ifc.secondsUpper, ifc.secondsLower, ifc.pm);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    $display("run   %0d cycles   mode=%0d out=%0d%0d:%0d%0d:%0d%0d", n, ifc.mode,
             ifc.hoursUpper, ifc.hoursLower, ifc.minutesUpper, ifc.minutesLower,
             ifc.secondsUpper, ifc.secondsLower);
  endtask

  task automatic set_digit(int loc, int target);
    int guard;
    guard = 0;
    while (m_loc != loc && guard < 4) begin press("next", 1'b0, 1'b1, 1'b0); guard++; end
    guard = 0;
    while (mdig(loc) != target && guard < 12) begin press("inc", 1'b0, 1'b0, 1'b1); guard++; end
  endtask

  task automatic set_time(int hh, int mm);
    set_digit(0, hh / 10);
    set_digit(1, hh % 10);
    set_digit(2, mm / 10);
    set_digit(3, mm % 10);
  endtask

  // press mode exactly on the cycle the prescaler is at its last count
  task automatic mode_on_tick();
    int guard;
    guard = 0;
    while (m_p != CLK_HZ - 1 && guard < 2 * CLK_HZ) begin step(1'b0, 1'b0, 1'b0); guard++; end
    check("tick_alignment", (m_p == CLK_HZ - 1) ? 32'd1 : 32'd0, 32'd1);
    press("mode@tick", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(string pfx);
    check({pfx, "_mode"}, ifc.mode, 0);
    check({pfx, "_loc"}, ifc.location, 0);
    check({pfx, "_hu"}, ifc.hoursUpper, 0);
    check({pfx, "_hl"}, ifc.hoursLower, 0);
    check({pfx, "_mu"}, ifc.minutesUpper, 0);
    check({pfx, "_ml"}, ifc.minutesLower, 0);
    check({pfx, "_su"}, ifc.secondsUpper, 0);
    check({pfx, "_sl"}, ifc.secondsLower, 0);
    check({pfx, "_blink"}, ifc.blink, 0);
    check({pfx, "_pm"}, ifc.pm, 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 200000", $time);
    $fatal(1);
  end

  initial begin
    int guard;
    ifc.btn_mode = 1'b0; ifc.btn_next = 1'b0; ifc.btn_inc = 1'b0;
    model_reset();
    #23;
    check_all_zero("reset");
    rst_n = 1'b1;
    run(3);

    // hoursUpper wraps 0..2, then hoursLower to 4
    press("inc", 1'b0, 1'b0, 1'b1); check("hu_inc1", ifc.hoursUpper, 1);
    press("inc", 1'b0, 1'b0, 1'b1); check("hu_inc2", ifc.hoursUpper, 2);
    press("inc", 1'b0, 1'b0, 1'b1); check("hu_inc3", ifc.hoursUpper, 0);
    press("next", 1'b0, 1'b1, 1'b0); check("loc_next", ifc.location, 1);
    for (int i = 0; i < 4; i++) press("inc", 1'b0, 1'b0, 1'b1);
    check("hl_four", ifc.hoursLower, 4);

    // 19 -> hoursUpper to 2 clamps hoursLower to 3
    set_digit(0, 1);
    set_digit(1, 9);
    check("hl_nine", ifc.hoursLower, 9);
    while (m_loc != 0) press("next", 1'b0, 1'b1, 1'b0);
    press("inc", 1'b0, 1'b0, 1'b1);
    check("clamp_hu", ifc.hoursUpper, 2);
    check("clamp_hl", ifc.hoursLower, 3);

    // hoursLower wraps at 3 when hoursUpper is 2
    press("next", 1'b0, 1'b1, 1'b0);
    press("inc", 1'b0, 1'b0, 1'b1); check("hl_wrap3", ifc.hoursLower, 0);
    for (int i = 0; i < 3; i++) press("inc", 1'b0, 1'b0, 1'b1);

    // minutes to 59; next+inc together only moves the cursor
    press("next", 1'b0, 1'b1, 1'b0);
    set_digit(2, 5);
    press("next+inc", 1'b0, 1'b1, 1'b1);
    check("next_wins_loc", ifc.location, 3);
    check("next_wins_ml", ifc.minutesLower, 0);
    set_digit(3, 9);

    // TIME24 from 23:59; first tick exactly CLK_HZ cycles later
    press("mode", 1'b1, 1'b0, 1'b0);
    check("time24_mode", ifc.mode, 1);
    run(CLK_HZ - 1);
    check("pre_first_tick", ifc.secondsLower, 0);
    run(1);
    check("first_tick", ifc.secondsLower, 1);
    run(58 * CLK_HZ);
    check("t235959_hl", ifc.hoursLower, 3);
    check("t235959_su", ifc.secondsUpper, 5);
    check("t235959_sl", ifc.secondsLower, 9);
    run(CLK_HZ);
    check("midnight_hu", ifc.hoursUpper, 0);
    check("midnight_hl", ifc.hoursLower, 0);
    check("midnight_mu", ifc.minutesUpper, 0);
    check("midnight_ml", ifc.minutesLower, 0);
    check("midnight_sl", ifc.secondsLower, 0);

    // running->running on a tick keeps the tick
    mode_on_tick();
    check("rr_tick_mode", ifc.mode, 2);
    check("rr_tick_sl", ifc.secondsLower, 1);
    press("mode", 1'b1, 1'b0, 1'b0);
    check("t12_00_hu", ifc.hoursUpper, 1);
    check("t12_00_hl", ifc.hoursLower, 2);
    check("t12_00_pm", ifc.pm, 0);

    // running->SETUP on a tick drops the tick
    mode_on_tick();
    check("rs_tick_mode", ifc.mode, 0);
    check("rs_tick_sl", ifc.secondsLower, 1);

    // 13:05, then mode+inc together: digits kept, seconds cleared
    set_time(13, 5);
    press("mode+inc", 1'b1, 1'b0, 1'b1);
    check("mi_mode", ifc.mode, 1);
    check("mi_hl", ifc.hoursLower, 3);
    check("mi_ml", ifc.minutesLower, 5);
    check("mi_sl", ifc.secondsLower, 0);
    press("mode", 1'b1, 1'b0, 1'b0);
    press("mode", 1'b1, 1'b0, 1'b0);
    check("t12_13_hu", ifc.hoursUpper, 0);
    check("t12_13_hl", ifc.hoursLower, 1);
    check("t12_13_pm", ifc.pm, 1);
    run(10);

    // 00:30 shown as 12 in TIME12, 00 in TIME24
    press("mode", 1'b1, 1'b0, 1'b0);
    set_time(0, 30);
    for (int i = 0; i < 3; i++) press("mode", 1'b1, 1'b0, 1'b0);
    check("t12_0030_hu", ifc.hoursUpper, 1);
    check("t12_0030_hl", ifc.hoursLower, 2);
    check("t12_0030_pm", ifc.pm, 0);
    press("mode", 1'b1, 1'b0, 1'b0);
    press("mode", 1'b1, 1'b0, 1'b0);
    check("t24_0030_hu", ifc.hoursUpper, 0);
    check("t24_0030_hl", ifc.hoursLower, 0);

    // asynchronous reset mid-run at 12:34:56
    for (int i = 0; i < 3; i++) press("mode", 1'b1, 1'b0, 1'b0);
    set_time(12, 34);
    press("mode", 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (m_s != 56 && guard < 400) begin step(1'b0, 1'b0, 1'b0); guard++; end
    guard = 0;
    while (m_p != 2 && guard < 8) begin step(1'b0, 1'b0, 1'b0); guard++; end
    check("pre_rst_hl", ifc.hoursLower, 2);
    check("pre_rst_ml", ifc.minutesLower, 4);
    check("pre_rst_su", ifc.secondsUpper, 5);
    check("pre_rst_sl", ifc.secondsLower, 6);
    #2 rst_n = 1'b0;
    #1;
    $display("reset asserted mid-run at t=%0t", $time);
    check_all_zero("async_rst");
    #2 rst_n = 1'b1;
    model_reset();
    run(6);
    press("mode", 1'b1, 1'b0, 1'b0);
    run(CLK_HZ);
    check("post_rst_tick", ifc.secondsLower, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
